// File: rtl/lfsr_keystream_gen_pkg.sv
// Shared types and the Galois step used by the keystream generator.
// galois_step works on a fixed maximum width; callers zero-extend and truncate.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } ks_state_e;

    typedef struct packed {
        logic [LFSR_MAX_W-1:0] next;
        logic                  out_bit;
    } step_t;

    // One Galois step: the bit shifted out selects whether the taps are folded in.
    function automatic step_t galois_step(input logic [LFSR_MAX_W-1:0] state,
                                          input logic [LFSR_MAX_W-1:0] taps);
        step_t r;
        r.out_bit = state[0];
        r.next    = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
        return r;
    endfunction

endpackage

// File: rtl/lfsr_keystream_gen_if.sv
// Valid/ready keystream word channel between the generator and the cipher stage.
interface lfsr_keystream_gen_if #(
    parameter int KW = 8
);
    logic          ks_valid;
    logic          ks_ready;
    logic [KW-1:0] ks_data;

    modport master (output ks_valid, output ks_data, input ks_ready);
    modport slave  (input ks_valid, input ks_data, output ks_ready);
endinterface

// File: rtl/lfsr_keystream_gen.sv
// Galois-LFSR keystream generator: packs KW serial bits per word and hands
// them out over valid/ready, with runtime seed/tap loading and lock-up guard.
module lfsr_keystream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               KW           = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(32'hA300_0000)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seed_load,
    input  logic [WIDTH-1:0]            seed_i,
    input  logic [WIDTH-1:0]            taps_i,
    input  logic                        en,
    lfsr_keystream_gen_if.master        ks,
    output logic [WIDTH-1:0]            state_o,
    output logic                        busy,
    output logic                        lockup
);

    localparam int               CNT_W    = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KW - 1);
    // Forcing the MSB tap means a nonzero register can never step to zero.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    ks_state_e        state_q,    state_d;
    logic [WIDTH-1:0] lfsr_q,     lfsr_d;
    logic [WIDTH-1:0] taps_q,     taps_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [KW-1:0]    coll_q,     coll_d;
    logic             ks_valid_q, ks_valid_d;
    logic [KW-1:0]    ks_data_q,  ks_data_d;
    logic             lockup_q,   lockup_d;
    step_t            step;

    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        taps_d     = taps_q;
        cnt_d      = cnt_q;
        coll_d     = coll_q;
        ks_valid_d = ks_valid_q;
        ks_data_d  = ks_data_q;
        lockup_d   = lockup_q;
        step       = galois_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(taps_q));

        if (seed_load) begin
            // A load wins over everything, including a word leaving this cycle.
            lfsr_d     = (seed_i == '0) ? DEFAULT_SEED : seed_i;
            taps_d     = taps_i | MSB_MASK;
            lockup_d   = (seed_i == '0);
            cnt_d      = '0;
            ks_valid_d = 1'b0;
            state_d    = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (en) begin
                        lfsr_d        = step.next[WIDTH-1:0];
                        coll_d[cnt_q] = step.out_bit;
                        if (cnt_q == CNT_LAST) begin
                            ks_data_d  = coll_d;
                            ks_valid_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (ks.ks_ready) begin
                        ks_valid_d = 1'b0;
                        state_d    = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            lfsr_q     <= DEFAULT_SEED;
            taps_q     <= DEFAULT_TAPS | MSB_MASK;
            cnt_q      <= '0;
            coll_q     <= '0;
            ks_valid_q <= 1'b0;
            ks_data_q  <= '0;
            lockup_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            taps_q     <= taps_d;
            cnt_q      <= cnt_d;
            coll_q     <= coll_d;
            ks_valid_q <= ks_valid_d;
            ks_data_q  <= ks_data_d;
            lockup_q   <= lockup_d;
        end
    end

    // Bits above WIDTH are always zero after the zero-extended step.
    if (WIDTH < LFSR_MAX_W) begin : g_unused
        logic unused_step_hi;
        assign unused_step_hi = |step.next[LFSR_MAX_W-1:WIDTH];
    end

    assign ks.ks_valid = ks_valid_q;
    assign ks.ks_data  = ks_data_q;
    assign state_o     = lfsr_q;
    assign busy        = (state_q == ST_FILL);
    assign lockup      = lockup_q;

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Self-checking bench for lfsr_keystream_gen: directed scenarios on an 8-bit
// instance, a randomized run against a word-level model, and a long 32-bit run.
module tb_lfsr_keystream_gen;

    localparam int K8  = 4;
    localparam int K32 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        seed_load8, en8, busy8, lockup8;
    logic [7:0]  seed8, taps8, state8;
    logic        seed_load32, en32, busy32, lockup32;
    logic [31:0] seed32, taps32, state32;

    lfsr_keystream_gen_if #(.KW(K8))  ks8 ();
    lfsr_keystream_gen_if #(.KW(K32)) ks32 ();

    lfsr_keystream_gen #(
        .WIDTH(8), .KW(K8), .DEFAULT_SEED(8'h01), .DEFAULT_TAPS(8'hB8)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load8), .seed_i(seed8),
        .taps_i(taps8), .en(en8), .ks(ks8), .state_o(state8), .busy(busy8),
        .lockup(lockup8)
    );

    lfsr_keystream_gen #(
        .WIDTH(32), .KW(K32), .DEFAULT_SEED(32'h1), .DEFAULT_TAPS(32'hA300_0000)
    ) dut32 (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load32), .seed_i(seed32),
        .taps_i(taps32), .en(en32), .ks(ks32), .state_o(state32), .busy(busy32),
        .lockup(lockup32)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference rule: halve the register; if an odd value was halved, fold in the taps.
    function automatic logic [63:0] ref_next(input logic [63:0] s, input logic [63:0] t);
        logic [63:0] half;
        half = s / 2;
        if (s % 2 == 1) return half ^ t;
        return half;
    endfunction

    // Word = the next kw output bits, first bit in the least significant place.
    task automatic ref_word(input logic [63:0] s_in, input logic [63:0] t, input int kw,
                            output logic [63:0] word, output logic [63:0] s_out);
        logic [63:0] s;
        s    = s_in;
        word = 0;
        for (int i = 0; i < kw; i++) begin
            word = word + ((s % 2) << i);
            s    = ref_next(s, t);
        end
        s_out = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] s, input logic [7:0] t);
        seed_load8 = 1'b1;
        seed8      = s;
        taps8      = t;
        tick();
        seed_load8 = 1'b0;
    endtask

    task automatic wait_valid8(input int budget, output int cycles);
        cycles = 0;
        while (!ks8.ks_valid && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ks8.ks_valid, ks8.ks_data, busy8, lockup8, state8} !== {1'b1 ^ 1'b1, 4'h0, 1'b1, 1'b0, 8'h01}) begin
            n_err++;
            $display("FAIL reset8: got valid=%b data=%h busy=%b lockup=%b state=%h, expected 0 0 1 0 01",
                     ks8.ks_valid, ks8.ks_data, busy8, lockup8, state8);
        end
        n_cmp++;
        if ({ks32.ks_valid, ks32.ks_data, busy32, lockup32, state32} !== {1'b0, 8'h00, 1'b1, 1'b0, 32'h1}) begin
            n_err++;
            $display("FAIL reset32: got valid=%b data=%h busy=%b lockup=%b state=%h, expected 0 00 1 0 00000001",
                     ks32.ks_valid, ks32.ks_data, busy32, lockup32, state32);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int c;
        ks8.ks_ready = 1'b1;
        en8          = 1'b1;
        load8(8'h01, 8'hB8);
        wait_valid8(20, c);
        n_cmp++;
        if (c !== 4 || ks8.ks_data !== 4'h1 || state8 !== 8'h17) begin
            n_err++;
            $display("FAIL basic_word1: got cycles=%0d data=%h state=%h, expected 4 1 17", c, ks8.ks_data, state8);
        end
        tick();
        n_cmp++;
        if (ks8.ks_valid !== 1'b0 || busy8 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_after_xfer: got valid=%b busy=%b, expected 0 1", ks8.ks_valid, busy8);
        end
        wait_valid8(20, c);
        n_cmp++;
        if (c !== 4 || ks8.ks_data !== 4'h7 || state8 !== 8'h64) begin
            n_err++;
            $display("FAIL basic_word2: got cycles=%0d data=%h state=%h, expected 4 7 64", c, ks8.ks_data, state8);
        end
    endtask

    task automatic test_backpressure();
        int c;
        ks8.ks_ready = 1'b0;
        en8          = 1'b1;
        load8(8'h01, 8'hB8);
        wait_valid8(20, c);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({ks8.ks_valid, ks8.ks_data, state8, busy8} !== {1'b1, 4'h1, 8'h17, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h state=%h busy=%b, expected 1 1 17 0",
                         i, ks8.ks_valid, ks8.ks_data, state8, busy8);
            end
        end
        ks8.ks_ready = 1'b1;
        tick();
        ks8.ks_ready = 1'b0;
        n_cmp++;
        if (ks8.ks_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b, expected 0", ks8.ks_valid);
        end
        wait_valid8(20, c);
        n_cmp++;
        if (c !== 4 || ks8.ks_data !== 4'h7 || state8 !== 8'h64) begin
            n_err++;
            $display("FAIL stall_word2: got cycles=%0d data=%h state=%h, expected 4 7 64", c, ks8.ks_data, state8);
        end
    endtask

    task automatic test_en_toggle();
        logic [3:0] exp_w [2];
        int got;
        int cyc;
        exp_w[0]     = 4'h1;
        exp_w[1]     = 4'h7;
        ks8.ks_ready = 1'b1;
        load8(8'h01, 8'hB8);
        got = 0;
        cyc = 0;
        en8 = 1'b0;
        while (got < 2 && cyc < 60) begin
            if (ks8.ks_valid) begin
                n_cmp++;
                if (ks8.ks_data !== exp_w[got] || (got == 0 && cyc != 8)) begin
                    n_err++;
                    $display("FAIL toggle_word%0d: got data=%h at cycle %0d, expected %h (first word at 8)",
                             got, ks8.ks_data, cyc, exp_w[got]);
                end
                got++;
            end
            tick();
            cyc++;
            en8 = ~en8;
        end
        n_cmp++;
        if (got != 2) begin
            n_err++;
            $display("FAIL toggle_timeout: got %0d words, expected 2", got);
        end
        en8 = 1'b1;
    endtask

    task automatic test_lockup();
        int c;
        ks8.ks_ready = 1'b1;
        en8          = 1'b1;
        load8(8'h00, 8'hB8);
        n_cmp++;
        if (lockup8 !== 1'b1 || state8 !== 8'h01) begin
            n_err++;
            $display("FAIL lockup_set: got lockup=%b state=%h, expected 1 01", lockup8, state8);
        end
        wait_valid8(20, c);
        n_cmp++;
        if (ks8.ks_data !== 4'h1 || lockup8 !== 1'b1) begin
            n_err++;
            $display("FAIL lockup_word: got data=%h lockup=%b, expected 1 1", ks8.ks_data, lockup8);
        end
        load8(8'h01, 8'hB8);
        n_cmp++;
        if (lockup8 !== 1'b0) begin
            n_err++;
            $display("FAIL lockup_clear: got lockup=%b, expected 0", lockup8);
        end
    endtask

    task automatic test_load_priority();
        int c;
        logic [63:0] w, s;
        ks8.ks_ready = 1'b0;
        en8          = 1'b1;
        load8(8'h01, 8'hB8);
        wait_valid8(20, c);
        ks8.ks_ready = 1'b1;
        load8(8'h5A, 8'h38);
        n_cmp++;
        if ({ks8.ks_valid, busy8, state8} !== {1'b0, 1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL prio_load: got valid=%b busy=%b state=%h, expected 0 1 5a", ks8.ks_valid, busy8, state8);
        end
        ref_word(64'h5A, 64'h38 | 64'h80, K8, w, s);
        wait_valid8(20, c);
        n_cmp++;
        if (c !== 4 || ks8.ks_data !== w[3:0] || state8 !== s[7:0]) begin
            n_err++;
            $display("FAIL prio_word: got cycles=%0d data=%h state=%h, expected 4 %h %h",
                     c, ks8.ks_data, state8, w[3:0], s[7:0]);
        end
        load8(8'h00, 8'hB8);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({ks8.ks_valid, ks8.ks_data, busy8, lockup8, state8} !== {1'b0, 4'h0, 1'b1, 1'b0, 8'h01}) begin
            n_err++;
            $display("FAIL mid_fill_reset: got valid=%b data=%h busy=%b lockup=%b state=%h, expected 0 0 1 0 01",
                     ks8.ks_valid, ks8.ks_data, busy8, lockup8, state8);
        end
        rst_n = 1'b1;
        wait_valid8(20, c);
        n_cmp++;
        if (c !== 4 || ks8.ks_data !== 4'h1 || state8 !== 8'h17) begin
            n_err++;
            $display("FAIL post_reset_word: got cycles=%0d data=%h state=%h, expected 4 1 17", c, ks8.ks_data, state8);
        end
    endtask

    task automatic test_random();
        logic [63:0] s_m, t_m, cur_w, cur_s;
        logic        lock_m, did_load;
        int          words;
        words = 0;
        en8   = 1'b1;
        load8(8'h3C, 8'h1D);
        s_m    = 64'h3C;
        t_m    = 64'h9D;
        lock_m = 1'b0;
        ref_word(s_m, t_m, K8, cur_w, cur_s);
        for (int i = 0; i < 400; i++) begin
            en8          = ($urandom_range(0, 3) != 0);
            ks8.ks_ready = $urandom_range(0, 1);
            did_load     = ($urandom_range(0, 29) == 0);
            seed_load8   = did_load;
            if (did_load) begin
                seed8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                taps8  = 8'($urandom);
                s_m    = (seed8 == 0) ? 64'h1 : 64'(seed8);
                t_m    = 64'(taps8) | 64'h80;
                lock_m = (seed8 == 0);
                ref_word(s_m, t_m, K8, cur_w, cur_s);
            end else if (ks8.ks_valid) begin
                n_cmp++;
                if ({ks8.ks_data, state8} !== {cur_w[3:0], cur_s[7:0]}) begin
                    n_err++;
                    $display("FAIL rand_word[%0d]: got data=%h state=%h, expected %h %h",
                             i, ks8.ks_data, state8, cur_w[3:0], cur_s[7:0]);
                end
                if (ks8.ks_ready) begin
                    words++;
                    s_m = cur_s;
                    ref_word(s_m, t_m, K8, cur_w, cur_s);
                end
            end
            tick();
            seed_load8 = 1'b0;
            if (did_load) begin
                n_cmp++;
                if (lockup8 !== lock_m || ks8.ks_valid !== 1'b0 || state8 !== s_m[7:0]) begin
                    n_err++;
                    $display("FAIL rand_load[%0d]: got lockup=%b valid=%b state=%h, expected %b 0 %h",
                             i, lockup8, ks8.ks_valid, state8, lock_m, s_m[7:0]);
                end
            end
        end
        n_cmp++;
        if (words < 10) begin
            n_err++;
            $display("FAIL rand_activity: got %0d words, expected at least 10", words);
        end
    endtask

    task automatic test_wide();
        logic [63:0] s, t, word;
        int          k, steps;
        bit          ok_match, ok_nonzero;
        ks32.ks_ready = 1'b1;
        en32          = 1'b1;
        seed_load32   = 1'b1;
        seed32        = $urandom | 32'h1;
        taps32        = $urandom & 32'h7FFF_FFFF;
        tick();
        seed_load32 = 1'b0;
        s          = 64'(seed32);
        t          = 64'(taps32) | 64'h8000_0000;
        word       = 0;
        k          = 0;
        steps      = 0;
        ok_match   = 1'b1;
        ok_nonzero = 1'b1;
        while (steps < 65536 && ok_match && ok_nonzero) begin
            if (state32 == 32'h0) begin
                ok_nonzero = 1'b0;
                $display("FAIL wide_nonzero: got state=0 after %0d steps, expected nonzero", steps);
            end else if (k == K32) begin
                if (!ks32.ks_valid || ks32.ks_data !== word[7:0] || state32 !== s[31:0]) begin
                    ok_match = 1'b0;
                    $display("FAIL wide_word: got valid=%b data=%h state=%h after %0d steps, expected 1 %h %h",
                             ks32.ks_valid, ks32.ks_data, state32, steps, word[7:0], s[31:0]);
                end
                k    = 0;
                word = 0;
            end else begin
                if (state32 !== s[31:0] || ks32.ks_valid !== 1'b0) begin
                    ok_match = 1'b0;
                    $display("FAIL wide_step: got state=%h valid=%b after %0d steps, expected %h 0",
                             state32, ks32.ks_valid, steps, s[31:0]);
                end
                word = word + ((s % 2) << k);
                s    = ref_next(s, t);
                k++;
                steps++;
            end
            if (ok_match && ok_nonzero) tick();
        end
        n_cmp++;
        if (!ok_match) n_err++;
        n_cmp++;
        if (!ok_nonzero) n_err++;
        n_cmp++;
        if (steps != 65536) begin
            n_err++;
            $display("FAIL wide_steps: got %0d steps, expected 65536", steps);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        seed_load8    = 1'b0;
        seed8         = '0;
        taps8         = '0;
        en8           = 1'b0;
        ks8.ks_ready  = 1'b0;
        seed_load32   = 1'b0;
        seed32        = '0;
        taps32        = '0;
        en32          = 1'b0;
        ks32.ks_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_en_toggle();
        test_lockup();
        test_load_priority();
        test_random();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
